fifo_out_rr_arbiter: RTL and testbench

Round-robin burst arbiter that merges NUM_REQ independent FIFO read-side streams onto a single downstream valid/ready port (data_out / data_out_vld / data_out_rdy). Each grant is locked for up to BURST_LEN beats, so short bursts stay contiguous. The output stage is registered. The block sits between the per-channel FIFO read ports and the shared consumer, and is driven and monitored through the existing fifo_out agent interface.

---
 rtl/fifo_out_pkg.sv | 21 ++
 rtl/fifo_out_rr_arbiter_if.sv | 34 +++
 rtl/rr_pick.sv | 36 +++
 rtl/fifo_out_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_fifo_out_rr_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_out_pkg.sv
// Shared types and constants for the fifo_out arbiter slice.
//   FIFO_DATA_W : default stream data width
//   fifo_data_t : one FIFO word at the default width
//   arb_state_e : arbiter FSM states
//   id_width()  : width of a requester index (at least 1 bit)
package fifo_out_pkg;

  localparam int unsigned FIFO_DATA_W = 16;

  typedef logic [FIFO_DATA_W-1:0] fifo_data_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_out_rr_arbiter_if.sv
// Bundle of the per-requester FIFO read ports and the merged downstream port.
//   in_data/in_vld/in_rdy          : NUM_REQ FIFO read streams (packed, requester i at [i*DATA_W +: DATA_W])
//   data_out/data_out_vld/data_out_rdy : merged valid/ready output
//   grant_id/busy                  : arbitration status
// slave modport is the arbiter side, master modport is the driver/monitor side.
interface fifo_out_rr_arbiter_if
  import fifo_out_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = FIFO_DATA_W
);

  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [NUM_REQ*DATA_W-1:0] in_data;
  logic [NUM_REQ-1:0]        in_vld;
  logic [NUM_REQ-1:0]        in_rdy;
  logic [DATA_W-1:0]         data_out;
  logic                      data_out_vld;
  logic                      data_out_rdy;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;

  modport slave (
    input  in_data, in_vld, data_out_rdy,
    output in_rdy, data_out, data_out_vld, grant_id, busy
  );

  modport master (
    output in_data, in_vld, data_out_rdy,
    input  in_rdy, data_out, data_out_vld, grant_id, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority selector: returns the first set bit of req
// found by searching upward from ptr with wrap-around.
//   req   : request vector
//   ptr   : index with highest priority (must be < N)
//   found : any request set
//   idx   : index of the selected request (0 when none)
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] idx
);

  localparam int unsigned SUM_W = ID_W + 1;

  logic [SUM_W-1:0] pos;

  // Walk offsets 0..N-1 from ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + SUM_W'(k);
      if (pos >= SUM_W'(N)) pos = pos - SUM_W'(N);
      if (!found && req[ID_W'(pos)]) begin
        found = 1'b1;
        idx   = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_out_rr_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ FIFO read streams onto one
// registered valid/ready output. A grant is held for up to BURST_LEN beats or
// until the granted stream runs dry; each new grant costs one idle cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fifo_out_rr_arbiter_if.slave (streams in, merged stream out, status)
module fifo_out_rr_arbiter
  import fifo_out_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = FIFO_DATA_W,
  parameter int unsigned BURST_LEN = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  fifo_out_rr_arbiter_if.slave bus
);

  localparam int unsigned     ID_W      = id_width(NUM_REQ);
  localparam int unsigned     CNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               data_out_vld_q, data_out_vld_d;

  logic               out_load_c;
  logic               xfer_c;
  logic               pick_found_c;
  logic [ID_W-1:0]    pick_idx_c;
  logic [ID_W-1:0]    rr_next_c;
  logic [NUM_REQ-1:0] in_rdy_c;
  logic [DATA_W-1:0]  grant_data_c;

  rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req   (bus.in_vld),
    .ptr   (rr_ptr_q),
    .found (pick_found_c),
    .idx   (pick_idx_c)
  );

  // Output register may take a new beat when empty or being drained this cycle.
  assign out_load_c = !data_out_vld_q || bus.data_out_rdy;

  assign rr_next_c = (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_W'(1);

  // Data of the currently granted requester.
  always_comb begin
    grant_data_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) grant_data_c = bus.in_data[i*DATA_W +: DATA_W];
    end
  end

  // Next-state, output-stage and handshake logic.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    beat_cnt_d     = beat_cnt_q;
    data_out_d     = data_out_q;
    data_out_vld_d = data_out_vld_q;
    in_rdy_c       = '0;
    xfer_c         = 1'b0;

    // A loadable output stage empties unless a new beat is written below.
    if (out_load_c) data_out_vld_d = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_found_c) begin
          grant_id_d = pick_idx_c;
          beat_cnt_d = '0;
          state_d    = ARB_BURST;
        end
      end
      ARB_BURST: begin
        // Gated by rst_n so no upstream word is consumed while in reset.
        in_rdy_c[grant_id_q] = out_load_c && rst_n;
        xfer_c = bus.in_vld[grant_id_q] && in_rdy_c[grant_id_q];
        if (xfer_c) begin
          data_out_d     = grant_data_c;
          data_out_vld_d = 1'b1;
          beat_cnt_d     = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = rr_next_c;
          end
        end else if (out_load_c && !bus.in_vld[grant_id_q]) begin
          // Granted stream ran dry: give up the grant without taking a beat.
          state_d  = ARB_IDLE;
          rr_ptr_d = rr_next_c;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ARB_IDLE;
      rr_ptr_q       <= '0;
      grant_id_q     <= '0;
      beat_cnt_q     <= '0;
      data_out_q     <= '0;
      data_out_vld_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      beat_cnt_q     <= beat_cnt_d;
      data_out_q     <= data_out_d;
      data_out_vld_q <= data_out_vld_d;
    end
  end

  assign bus.in_rdy       = in_rdy_c;
  assign bus.data_out     = data_out_q;
  assign bus.data_out_vld = data_out_vld_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.busy         = (state_q == ARB_BURST);

endmodule

// File: tb/tb_fifo_out_rr_arbiter.sv
// Self-checking bench for fifo_out_rr_arbiter (NUM_REQ=4, DATA_W=16, BURST_LEN=4).
// Each requester is modelled as a FIFO queue; word k of requester i is {i, k}.
module tb_fifo_out_rr_arbiter;
  import fifo_out_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 16;

  logic clk;
  logic rst_n;

  fifo_out_rr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  fifo_out_rr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .BURST_LEN (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo_data_t   q [NR][$];
  logic [NR-1:0] in_rdy_s;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          rst_n;
    logic [NR-1:0] en;
    logic          rdy;
    logic [NR-1:0] e_in_rdy;
    logic          e_vld;
    logic [DW-1:0] e_data;
    logic [1:0]    e_gid;
    logic          e_busy;
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample in_rdy before the edge, pop accepted words after it.
  task automatic step(input logic r, input logic [NR-1:0] en, input logic rd);
    logic [NR-1:0] hs;
    rst_n = r;
    bus.data_out_rdy = rd;
    for (int i = 0; i < int'(NR); i++) begin
      bus.in_vld[i] = en[i] && (q[i].size() != 0);
      bus.in_data[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : '0;
    end
    #3;
    in_rdy_s = bus.in_rdy;
    hs = bus.in_vld & bus.in_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(NR); i++) begin
      if (hs[i]) void'(q[i].pop_front());
    end
  endtask

  task automatic fill(input int src, input int n);
    for (int k = 1; k <= n; k++) q[src].push_back({8'(src), 8'(k)});
  endtask

  task automatic clear_and_reset();
    for (int i = 0; i < int'(NR); i++) q[i].delete();
    step(1'b0, '0, 1'b1);
  endtask

  task automatic check_out(input string tag, input logic evld, input logic [DW-1:0] edata,
                           input logic [1:0] egid, input logic ebusy);
    chk({tag, "_vld"}, 32'(bus.data_out_vld), 32'(evld));
    if (evld) chk({tag, "_data"}, 32'(bus.data_out), 32'(edata));
    chk({tag, "_gid"}, 32'(bus.grant_id), 32'(egid));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(ebusy));
  endtask

  initial begin
    int beat;
    int src_cnt [NR];
    int s;

    rst_n = 1'b0;
    bus.in_vld = '0;
    bus.in_data = '0;
    bus.data_out_rdy = 1'b1;
    in_rdy_s = '0;

    // Reset with all streams valid, then a single-stream sequence on requester 1.
    //        rst   en     rdy   in_rdy  vld   data      gid busy
    tv[0]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 16'h0000, 2'd0, 1'b0};
    tv[1]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 16'h0000, 2'd0, 1'b0};
    tv[2]  = '{1'b1, 4'h3, 1'b1, 4'h0, 1'b0, 16'h0000, 2'd0, 1'b1};
    tv[3]  = '{1'b1, 4'h3, 1'b1, 4'h1, 1'b1, 16'h0001, 2'd0, 1'b1};
    tv[4]  = '{1'b1, 4'h3, 1'b1, 4'h1, 1'b0, 16'h0000, 2'd0, 1'b0};
    tv[5]  = '{1'b1, 4'h3, 1'b1, 4'h0, 1'b0, 16'h0000, 2'd1, 1'b1};
    tv[6]  = '{1'b1, 4'h3, 1'b1, 4'h2, 1'b1, 16'h0101, 2'd1, 1'b1};
    tv[7]  = '{1'b1, 4'h3, 1'b1, 4'h2, 1'b1, 16'h0102, 2'd1, 1'b1};
    tv[8]  = '{1'b1, 4'h3, 1'b1, 4'h2, 1'b1, 16'h0103, 2'd1, 1'b1};
    tv[9]  = '{1'b1, 4'h3, 1'b1, 4'h2, 1'b1, 16'h0104, 2'd1, 1'b0};
    tv[10] = '{1'b1, 4'h3, 1'b1, 4'h0, 1'b0, 16'h0000, 2'd1, 1'b1};
    tv[11] = '{1'b1, 4'h3, 1'b1, 4'h2, 1'b1, 16'h0105, 2'd1, 1'b1};
    tv[12] = '{1'b1, 4'h3, 1'b1, 4'h2, 1'b1, 16'h0106, 2'd1, 1'b1};
    tv[13] = '{1'b1, 4'h3, 1'b1, 4'h2, 1'b0, 16'h0000, 2'd1, 1'b0};
    tv[14] = '{1'b1, 4'h3, 1'b1, 4'h0, 1'b0, 16'h0000, 2'd1, 1'b0};

    fill(0, 1);
    fill(1, 6);
    fill(2, 1);
    fill(3, 1);
    step(1'b0, 4'hF, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step(tv[i].rst_n, tv[i].en, tv[i].rdy);
      chk($sformatf("A%0d_in_rdy", i), 32'(in_rdy_s), 32'(tv[i].e_in_rdy));
      chk($sformatf("A%0d_vld", i), 32'(bus.data_out_vld), 32'(tv[i].e_vld));
      if (tv[i].e_vld || !tv[i].rst_n)
        chk($sformatf("A%0d_data", i), 32'(bus.data_out), 32'(tv[i].e_data));
      chk($sformatf("A%0d_gid", i), 32'(bus.grant_id), 32'(tv[i].e_gid));
      chk($sformatf("A%0d_busy", i), 32'(bus.busy), 32'(tv[i].e_busy));
    end

    // All four streams continuously valid: order 0,1,2,3,0, 4-beat bursts, one idle cycle between.
    clear_and_reset();
    for (int i = 0; i < int'(NR); i++) begin
      fill(i, 12);
      src_cnt[i] = 0;
    end
    beat = 0;
    for (int t = 0; t < 25; t++) begin
      step(1'b1, 4'hF, 1'b1);
      chk($sformatf("B%0d_vld", t), 32'(bus.data_out_vld), 32'((t % 5) != 0));
      if (bus.data_out_vld) begin
        s = (beat / 4) % 4;
        chk($sformatf("B%0d_data", t), 32'(bus.data_out), 32'({8'(s), 8'(src_cnt[s] + 1)}));
        chk($sformatf("B%0d_gid", t), 32'(bus.grant_id), 32'(s));
        src_cnt[s]++;
        beat++;
      end
    end
    chk("B_beats", 32'(beat), 32'd20);
    chk("B_q0_left", 32'(q[0].size()), 32'd4);
    chk("B_q1_left", 32'(q[1].size()), 32'd8);
    chk("B_q2_left", 32'(q[2].size()), 32'd8);
    chk("B_q3_left", 32'(q[3].size()), 32'd8);

    // Early dry-out: req2 gives 2 beats, then req3 must win over a newly valid req0.
    clear_and_reset();
    fill(2, 2);
    fill(3, 3);
    fill(0, 1);
    step(1'b1, 4'hC, 1'b1); check_out("C0", 1'b0, 16'h0000, 2'd2, 1'b1);
    step(1'b1, 4'hC, 1'b1); check_out("C1", 1'b1, 16'h0201, 2'd2, 1'b1);
    chk("C1_in_rdy", 32'(in_rdy_s), 32'h4);
    step(1'b1, 4'hC, 1'b1); check_out("C2", 1'b1, 16'h0202, 2'd2, 1'b1);
    step(1'b1, 4'hD, 1'b1); check_out("C3", 1'b0, 16'h0000, 2'd2, 1'b0);
    step(1'b1, 4'hD, 1'b1); check_out("C4", 1'b0, 16'h0000, 2'd3, 1'b1);
    step(1'b1, 4'hD, 1'b1); check_out("C5", 1'b1, 16'h0301, 2'd3, 1'b1);
    step(1'b1, 4'hD, 1'b1); check_out("C6", 1'b1, 16'h0302, 2'd3, 1'b1);
    step(1'b1, 4'hD, 1'b1); check_out("C7", 1'b1, 16'h0303, 2'd3, 1'b1);
    step(1'b1, 4'hD, 1'b1); check_out("C8", 1'b0, 16'h0000, 2'd3, 1'b0);
    step(1'b1, 4'hD, 1'b1); check_out("C9", 1'b0, 16'h0000, 2'd0, 1'b1);
    step(1'b1, 4'hD, 1'b1); check_out("C10", 1'b1, 16'h0001, 2'd0, 1'b1);

    // Backpressure for 5 cycles after the 2nd beat; burst must still be 4 beats.
    clear_and_reset();
    fill(0, 6);
    step(1'b1, 4'h1, 1'b1); check_out("D0", 1'b0, 16'h0000, 2'd0, 1'b1);
    step(1'b1, 4'h1, 1'b1); check_out("D1", 1'b1, 16'h0001, 2'd0, 1'b1);
    step(1'b1, 4'h1, 1'b1); check_out("D2", 1'b1, 16'h0002, 2'd0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 4'h1, 1'b0);
      chk($sformatf("D_stall%0d_in_rdy", c), 32'(in_rdy_s), 32'h0);
      check_out($sformatf("D_stall%0d", c), 1'b1, 16'h0002, 2'd0, 1'b1);
    end
    step(1'b1, 4'h1, 1'b1); check_out("D8", 1'b1, 16'h0003, 2'd0, 1'b1);
    step(1'b1, 4'h1, 1'b1); check_out("D9", 1'b1, 16'h0004, 2'd0, 1'b0);
    chk("D9_q0_left", 32'(q[0].size()), 32'd2);
    step(1'b1, 4'h1, 1'b1); check_out("D10", 1'b0, 16'h0000, 2'd0, 1'b1);
    step(1'b1, 4'h1, 1'b1); check_out("D11", 1'b1, 16'h0005, 2'd0, 1'b1);

    // Reset on the 2nd beat of a req0 burst; delivery resumes with the first unaccepted word.
    clear_and_reset();
    fill(0, 6);
    step(1'b1, 4'h1, 1'b1); check_out("E0", 1'b0, 16'h0000, 2'd0, 1'b1);
    step(1'b1, 4'h1, 1'b1); check_out("E1", 1'b1, 16'h0001, 2'd0, 1'b1);
    step(1'b0, 4'h1, 1'b1);
    chk("E2_in_rdy", 32'(in_rdy_s), 32'h0);
    chk("E2_data", 32'(bus.data_out), 32'h0);
    check_out("E2", 1'b0, 16'h0000, 2'd0, 1'b0);
    chk("E2_q0_left", 32'(q[0].size()), 32'd5);
    step(1'b1, 4'h1, 1'b1); check_out("E3", 1'b0, 16'h0000, 2'd0, 1'b1);
    step(1'b1, 4'h1, 1'b1); check_out("E4", 1'b1, 16'h0002, 2'd0, 1'b1);
    step(1'b1, 4'h1, 1'b1); check_out("E5", 1'b1, 16'h0003, 2'd0, 1'b1);
    step(1'b1, 4'h1, 1'b1); check_out("E6", 1'b1, 16'h0004, 2'd0, 1'b1);
    step(1'b1, 4'h1, 1'b1); check_out("E7", 1'b1, 16'h0005, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
